// File: rtl/tlb_pkg.sv
// Shared TLB constants and the per-page payload carried by each entry.
package tlb_pkg;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IDXW   = 4;
    localparam int unsigned VPN2_W = 19;
    localparam int unsigned ASID_W = 8;
    localparam int unsigned PFN_W  = 20;
    localparam int unsigned C_W    = 3;

    // One page half (even or odd) of a TLB entry.
    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [C_W-1:0]   c;
        logic             d;
        logic             v;
    } page_t;

endpackage

// File: rtl/tlb_match.sv
// Associative search of one key against all TLB tags.
// Ports: vpn2/asid = search key; e_vpn2/e_asid/e_g = tags of every entry;
//        found = any entry matches; index = lowest matching entry (0 on miss).
module tlb_match
    import tlb_pkg::*;
(
    input  logic [VPN2_W-1:0]              vpn2,
    input  logic [ASID_W-1:0]              asid,
    input  logic [TLBNUM-1:0][VPN2_W-1:0]  e_vpn2,
    input  logic [TLBNUM-1:0][ASID_W-1:0]  e_asid,
    input  logic [TLBNUM-1:0]              e_g,
    output logic                           found,
    output logic [IDXW-1:0]                index
);

    logic [TLBNUM-1:0] match;

    // Per-entry tag compare; global entries ignore the ASID.
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(TLBNUM); i++) begin
            match[i] = (e_vpn2[i] == vpn2) && (e_g[i] || (e_asid[i] == asid));
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        index = '0;
        for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
            if (match[i]) begin
                index = IDXW'(i);
            end
        end
    end

    assign found = |match;

endmodule

// File: rtl/tlb.sv
// Unified fully associative TLB: two combinational lookup ports (fetch, data),
// TLBWI write, combinational TLBR read and a one-cycle registered TLBP probe.
// Ports: s0_*/s1_* lookup request/result; we/w_* entry write; r_index/r_* read;
//        TLBP/EntryHi probe request; probe_done/probe_found/probe_index result.
module tlb
    import tlb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,

    input  logic [18:0]       s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [7:0]        s0_asid,
    output logic              s0_found,
    output logic [IDXW-1:0]   s0_index,
    output logic [19:0]       s0_pfn,
    output logic [2:0]        s0_c,
    output logic              s0_d,
    output logic              s0_v,

    input  logic [18:0]       s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [7:0]        s1_asid,
    output logic              s1_found,
    output logic [IDXW-1:0]   s1_index,
    output logic [19:0]       s1_pfn,
    output logic [2:0]        s1_c,
    output logic              s1_d,
    output logic              s1_v,

    input  logic              we,
    input  logic [IDXW-1:0]   w_index,
    input  logic [18:0]       w_vpn2,
    input  logic [7:0]        w_asid,
    input  logic              w_g,
    input  logic [19:0]       w_pfn0,
    input  logic [2:0]        w_c0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [19:0]       w_pfn1,
    input  logic [2:0]        w_c1,
    input  logic              w_d1,
    input  logic              w_v1,

    input  logic [IDXW-1:0]   r_index,
    output logic [18:0]       r_vpn2,
    output logic [7:0]        r_asid,
    output logic              r_g,
    output logic [19:0]       r_pfn0,
    output logic [2:0]        r_c0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [19:0]       r_pfn1,
    output logic [2:0]        r_c1,
    output logic              r_d1,
    output logic              r_v1,

    input  logic              TLBP,
    input  logic [31:0]       EntryHi,
    output logic              probe_done,
    output logic              probe_found,
    output logic [IDXW-1:0]   probe_index
);

    logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_q;
    logic [TLBNUM-1:0][ASID_W-1:0] asid_q;
    logic [TLBNUM-1:0]             g_q;
    page_t [TLBNUM-1:0]            pg0_q;
    page_t [TLBNUM-1:0]            pg1_q;

    page_t                         s0_pg;
    page_t                         s1_pg;
    logic                          pr_found;
    logic [IDXW-1:0]               pr_index;
    logic                          unused_entryhi;

    // Entry storage; everything is cleared so V/G start at 0 and sims stay X-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vpn2_q <= '0;
            asid_q <= '0;
            g_q    <= '0;
            pg0_q  <= '0;
            pg1_q  <= '0;
        end else if (we) begin
            vpn2_q[w_index] <= w_vpn2;
            asid_q[w_index] <= w_asid;
            g_q[w_index]    <= w_g;
            pg0_q[w_index]  <= '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0};
            pg1_q[w_index]  <= '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1};
        end
    end

    tlb_match u_match_s0 (
        .vpn2   (s0_vpn2),
        .asid   (s0_asid),
        .e_vpn2 (vpn2_q),
        .e_asid (asid_q),
        .e_g    (g_q),
        .found  (s0_found),
        .index  (s0_index)
    );

    tlb_match u_match_s1 (
        .vpn2   (s1_vpn2),
        .asid   (s1_asid),
        .e_vpn2 (vpn2_q),
        .e_asid (asid_q),
        .e_g    (g_q),
        .found  (s1_found),
        .index  (s1_index)
    );

    tlb_match u_match_probe (
        .vpn2   (EntryHi[31:13]),
        .asid   (EntryHi[7:0]),
        .e_vpn2 (vpn2_q),
        .e_asid (asid_q),
        .e_g    (g_q),
        .found  (pr_found),
        .index  (pr_index)
    );

    // EntryHi[12:8] is not part of the probe key.
    assign unused_entryhi = ^EntryHi[12:8];

    // Page select for the lookup ports; a miss returns all-zero page data.
    always_comb begin
        s0_pg = '0;
        s1_pg = '0;
        if (s0_found) begin
            s0_pg = s0_odd_page ? pg1_q[s0_index] : pg0_q[s0_index];
        end
        if (s1_found) begin
            s1_pg = s1_odd_page ? pg1_q[s1_index] : pg0_q[s1_index];
        end
    end

    assign s0_pfn = s0_pg.pfn;
    assign s0_c   = s0_pg.c;
    assign s0_d   = s0_pg.d;
    assign s0_v   = s0_pg.v;
    assign s1_pfn = s1_pg.pfn;
    assign s1_c   = s1_pg.c;
    assign s1_d   = s1_pg.d;
    assign s1_v   = s1_pg.v;

    assign r_vpn2 = vpn2_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_pfn0 = pg0_q[r_index].pfn;
    assign r_c0   = pg0_q[r_index].c;
    assign r_d0   = pg0_q[r_index].d;
    assign r_v0   = pg0_q[r_index].v;
    assign r_pfn1 = pg1_q[r_index].pfn;
    assign r_c1   = pg1_q[r_index].c;
    assign r_d1   = pg1_q[r_index].d;
    assign r_v1   = pg1_q[r_index].v;

    // Probe result register; found/index hold between probes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            probe_done  <= 1'b0;
            probe_found <= 1'b0;
            probe_index <= '0;
        end else begin
            probe_done <= TLBP;
            if (TLBP) begin
                probe_found <= pr_found;
                probe_index <= pr_index;
            end
        end
    end

endmodule
